// File: rtl/mt_state_ctrl.sv
// mt_state_ctrl: sequencer for the N-word dual-port MT19937 state SRAM.
// Seeds the state array from a 32-bit seed, then twists it in place one word
// per two cycles and streams each new word on a valid/ready interface.
//
// Optional build macro: MT_TEMPER_EN
//   defined   -> out_data carries the MT19937-tempered word
//   undefined -> out_data carries the raw new state word (debug)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   seed_valid, seed        load a new seed (always accepted, highest priority)
//   busy                    high while the state array is being seeded
//   out_valid, out_ready,
//   out_data                generated-word stream
//   sram_wr, sram_addr1,
//   sram_di, sram_do1       SRAM port 1 (read/write, registered read data)
//   sram_addr2, sram_do2    SRAM port 2 (read only, registered read data)
module mt_state_ctrl #(
  parameter  int unsigned N  = 624,
  parameter  int unsigned M  = 397,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          seed_valid,
  input  logic [31:0]   seed,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          sram_wr,
  output logic [AW-1:0] sram_addr1,
  output logic [AW-1:0] sram_addr2,
  output logic [31:0]   sram_di,
  input  logic [31:0]   sram_do1,
  input  logic [31:0]   sram_do2
);

  localparam logic [AW-1:0] LAST     = AW'(N - 1);
  localparam logic [AW-1:0] WRAP_IDX = AW'(N - M);
  localparam logic [AW-1:0] OFS_M    = AW'(M);
  localparam logic [31:0]   MATRIX_A = 32'h9908_B0DF;
  localparam logic [31:0]   INIT_MUL = 32'd1812433253;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_RD,
    ST_WR
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] k_q, k_d;
  logic [31:0]   cur_q, cur_d;
  logic [31:0]   prev_q, prev_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;

  logic [AW-1:0] i_next_c;
  logic [AW-1:0] addr_m_c;
  logic [31:0]   seed_word_c;
  logic [31:0]   y_c;
  logic [31:0]   twist_c;
  logic [31:0]   out_word_c;
  logic          slot_free_c;

`ifdef MT_TEMPER_EN
  // MT19937 output tempering.
  function automatic logic [31:0] temper(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C_5680);
    y = y ^ ((y << 15) & 32'hEFC6_0000);
    y = y ^ (y >> 18);
    return y;
  endfunction
`endif

  // Index arithmetic: wrap without a divider.
  always_comb begin
    i_next_c = (i_q == LAST) ? '0 : i_q + AW'(1);
    addr_m_c = (i_q >= WRAP_IDX) ? i_q - WRAP_IDX : i_q + OFS_M;
  end

  // Seeding recurrence and twist datapath.
  always_comb begin
    seed_word_c = 32'(INIT_MUL * (prev_q ^ (prev_q >> 30))) + 32'(k_q);
    // cur_q holds the old x[i]; sram_do1 is x[i+1], sram_do2 is x[i+M].
    y_c         = {cur_q[31], sram_do1[30:0]};
    twist_c     = sram_do2 ^ {1'b0, y_c[31:1]} ^ (y_c[0] ? MATRIX_A : 32'h0);
`ifdef MT_TEMPER_EN
    out_word_c  = temper(twist_c);
`else
    out_word_c  = twist_c;
`endif
    slot_free_c = !out_valid_q || out_ready;
  end

  // Next-state and SRAM control.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    k_d         = k_q;
    cur_d       = cur_q;
    prev_d      = prev_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy        = 1'b0;
    sram_wr     = 1'b0;
    sram_addr1  = '0;
    sram_addr2  = '0;
    sram_di     = '0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
      end
      ST_SEED: begin
        busy       = 1'b1;
        sram_wr    = 1'b1;
        sram_addr1 = k_q;
        // prev_q was loaded with the seed itself, so k=0 writes the seed.
        sram_di    = (k_q == '0) ? prev_q : seed_word_c;
        prev_d     = sram_di;
        if (k_q == LAST) begin
          state_d = ST_RD;
          i_d     = '0;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      ST_RD: begin
        sram_addr1 = i_next_c;
        sram_addr2 = addr_m_c;
        state_d    = ST_WR;
      end
      ST_WR: begin
        if (slot_free_c) begin
          sram_wr     = 1'b1;
          sram_addr1  = i_q;
          sram_di     = twist_c;
          out_data_d  = out_word_c;
          out_valid_d = 1'b1;
          cur_d       = sram_do1;
          i_d         = i_next_c;
          state_d     = ST_RD;
        end else begin
          // Re-read the same words so the read registers stay stable.
          sram_addr1 = i_next_c;
          sram_addr2 = addr_m_c;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new seed overrides everything, including a pending WR write.
    if (seed_valid) begin
      state_d     = ST_SEED;
      k_d         = '0;
      prev_d      = seed;
      cur_d       = seed;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      i_d         = i_q;
      if (state_q == ST_WR) begin
        sram_wr = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      k_q         <= '0;
      cur_q       <= '0;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      k_q         <= k_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mt_state_ctrl.sv
// Testbench for mt_state_ctrl: SRAM model, MT19937 reference model and a
// per-cycle compare process, driven with randomized backpressure and reseeds.
module tb_mt_state_ctrl;

  localparam int N  = 624;
  localparam int M  = 397;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          seed_valid = 1'b0;
  logic [31:0]   seed = '0;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic          sram_wr;
  logic [AW-1:0] sram_addr1;
  logic [AW-1:0] sram_addr2;
  logic [31:0]   sram_di;
  logic [31:0]   sram_do1 = '0;
  logic [31:0]   sram_do2 = '0;

  int checks = 0;
  int failures = 0;

  mt_state_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_valid (seed_valid),
    .seed       (seed),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sram_wr    (sram_wr),
    .sram_addr1 (sram_addr1),
    .sram_addr2 (sram_addr2),
    .sram_di    (sram_di),
    .sram_do1   (sram_do1),
    .sram_do2   (sram_do2)
  );

  always #5 clk = ~clk;

  // Dual-port SRAM: registered reads, read-before-write on port 1.
  logic [31:0] mem [N];
  initial for (int a = 0; a < N; a++) mem[a] = '0;
  always @(posedge clk) begin
    if (int'(sram_addr1) < N) begin
      sram_do1 <= mem[sram_addr1];
      if (sram_wr) mem[sram_addr1] <= sram_di;
    end
    if (int'(sram_addr2) < N) sram_do2 <= mem[sram_addr2];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] temper(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C_5680);
    y = y ^ ((y << 15) & 32'hEFC6_0000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  // Reference model: plain MT19937 state array and generation index.
  logic [31:0] init_v [N];
  logic [31:0] mt [N];
  int          mi;
  int          model_cnt = 0;
  logic [31:0] model_seed = '0;

  task automatic model_seed_task(input logic [31:0] s);
    init_v[0] = s;
    for (int k = 1; k < N; k++)
      init_v[k] = 32'd1812433253 * (init_v[k-1] ^ (init_v[k-1] >> 30)) + 32'(k);
    for (int k = 0; k < N; k++) mt[k] = init_v[k];
    mi         = 0;
    model_cnt  = 0;
    model_seed = s;
  endtask

  task automatic model_next(output logic [31:0] raw);
    logic [31:0] y;
    y = (mt[mi] & 32'h8000_0000) | (mt[(mi + 1) % N] & 32'h7FFF_FFFF);
    mt[mi] = mt[(mi + M) % N] ^ (y >> 1) ^ (y[0] ? 32'h9908_B0DF : 32'h0);
    raw = mt[mi];
    mi = (mi + 1) % N;
    model_cnt++;
  endtask

  logic [31:0] pin5489 [3];
  initial begin
    pin5489[0] = 32'd3499211612;
    pin5489[1] = 32'd581869302;
    pin5489[2] = 32'd3890346734;
  end

  // Per-cycle compare process.
  logic        armed = 1'b0;
  int          since = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    logic [31:0] raw, exp_w;
    if (!rst_n) begin
      armed      = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (armed) since++;
      if (!armed) begin
        chk("idle_wr", 32'(sram_wr), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
      end else begin
        chk("busy", 32'(busy), 32'(since >= 1 && since <= N));
        chk("addr_range", 32'(int'(sram_addr1) < N && int'(sram_addr2) < N), 32'd1);
        if (since >= 1 && since <= N) begin
          chk("seed_wr", 32'(sram_wr), 32'd1);
          chk("seed_addr", 32'(sram_addr1), 32'(since - 1));
          chk("seed_di", sram_di, init_v[since-1]);
        end
        if (since <= N + 2) chk("valid_quiet", 32'(out_valid), 32'd0);
        else if (since == N + 3) chk("first_latency", 32'(out_valid), 32'd1);
        if (prev_stall) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", out_data, prev_data);
        end
        if (out_valid && !out_ready && !seed_valid) chk("stall_no_wr", 32'(sram_wr), 32'd0);
        if (out_valid && out_ready && !seed_valid) begin
          model_next(raw);
`ifdef MT_TEMPER_EN
          exp_w = temper(raw);
`else
          exp_w = raw;
`endif
          chk("word", out_data, exp_w);
          if (model_seed == 32'd5489 && model_cnt <= 3) chk("pin_5489", temper(raw), pin5489[model_cnt-1]);
          if (model_seed == 32'd5489 && model_cnt == 10000) chk("pin_word10000", temper(raw), 32'd4123659995);
          if (model_seed == 32'd1 && model_cnt == 1) chk("pin_seed1", temper(raw), 32'd1791095845);
        end
      end
      prev_stall = armed && out_valid && !out_ready && !seed_valid;
      prev_data  = out_data;
      if (seed_valid) begin
        model_seed_task(seed);
        armed = 1'b1;
        since = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_wr"}, 32'(sram_wr), 32'd0);
    chk({tag, "_addr1"}, 32'(sram_addr1), 32'd0);
    chk({tag, "_addr2"}, 32'(sram_addr2), 32'd0);
    chk({tag, "_di"}, sram_di, 32'd0);
  endtask

  task automatic send_seed(input logic [31:0] s);
    seed       = s;
    seed_valid = 1'b1;
    @(posedge clk);
    #1 seed_valid = 1'b0;
  endtask

  task automatic run_words(input int target, input int budget, input bit random_ready);
    int c;
    c = 0;
    while (model_cnt < target && c < budget) begin
      @(posedge clk);
      #1;
      if (random_ready) out_ready = ($urandom_range(3) != 0);
      c++;
    end
    chk("run_timeout", 32'(model_cnt >= target), 32'd1);
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    send_seed(32'd5489);
    chk("pin_init1", init_v[1], 32'd1301868182);

    // Seeding phase, then state array contents.
    c = 0;
    while (busy && c < 700) begin @(posedge clk); #1; c++; end
    chk("seed_done", 32'(busy), 32'd0);
    chk("sram0", mem[0], 32'd5489);
    chk("sram1", mem[1], 32'd1301868182);

    // First word, then hold it under backpressure.
    c = 0;
    while (!out_valid && c < 10) begin @(posedge clk); #1; c++; end
    chk("first_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
`ifdef MT_TEMPER_EN
    chk("bp_literal", out_data, 32'd3499211612);
`endif
    out_ready = 1'b1;

    // Long run through many index wraps with random backpressure.
    run_words(10000, 40000, 1'b1);

    // Reseed while a word is pending in WR.
    out_ready = 1'b0;
    c = 0;
    while (!out_valid && c < 10) begin @(posedge clk); #1; c++; end
    chk("pending_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 send_seed(32'd1);
    chk("reseed_drop", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    run_words(50, 2000, 1'b0);

    // Asynchronous reset in the middle of seeding.
    send_seed($urandom);
    repeat (299) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 send_seed($urandom);
    run_words(300, 3000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mt_state_ctrl.md
Name: mt_state_ctrl

Overview:
- Sequencer for the 624-word dual-port MT19937 state SRAM.
- Seeds the state array from a 32-bit seed, then runs the twist in place: reads x[i+1] on port 1 and x[i+M] on port 2, writes the new x[i] back on port 1.
- Presents tempered 32-bit random words on a valid/ready stream; sits between the SRAM and the consumer.

Parameters:
N, 624, state words (SRAM depth); address width AW = $clog2(N)
M, 397, twist middle offset

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
seed_valid  in  1  load new seed (always accepted; no ready)
seed  in  32  seed value
busy  out  1  high while in SEED state
out_valid  out  1  out_data holds a word
out_ready  in  1  consumer accepts word when out_valid && out_ready
out_data  out  32  generated word
sram_wr  out  1  port-1 write enable
sram_addr1  out  AW  port-1 address (read/write)
sram_addr2  out  AW  port-2 address (read only)
sram_di  out  32  write data
sram_do1  in  32  port-1 read data, registered (valid 1 cycle after address)
sram_do2  in  32  port-2 read data, registered

Behaviour:
- SRAM: read-before-write on port 1; read latency 1; sram_* driven combinationally from registered state.
- Reset (async, rst_n=0): state IDLE, i=0, k=0, cur=0, prev=0, out_valid=0, out_data=0; hence sram_wr=0, addr1=addr2=0, sram_di=0, busy=0.
- States IDLE, SEED, RD, WR.
- IDLE: no SRAM activity, no output.
- seed_valid in any state: next state SEED, k=0, prev=seed, cur=seed, out_valid=0 (pending word discarded). Takes priority over every other transition.
- SEED (busy=1): sram_wr=1, addr1=k.
  - sram_di = seed when k=0, else 1812433253*(prev^(prev>>30))+k, mod 2^32.
  - prev <= sram_di each cycle; k increments; after k=N-1 written, next state RD with i=0.
  - Exactly N cycles.
- RD: wr=0, addr1=(i+1) mod N, addr2=(i+M) mod N (i+M-N when i>=N-M, no divider). Next state WR.
- WR: y=(cur&0x80000000)|(sram_do1&0x7FFFFFFF); new = sram_do2 ^ (y>>1) ^ (y[0] ? 0x9908B0DF : 0).
  - Slot free (!out_valid || out_ready):
    - sram_wr=1, addr1=i, sram_di=new.
    - out_data <= T(new), out_valid <= 1.
    - cur <= sram_do1, i <= (i==N-1) ? 0 : i+1.
    - Next state RD.
  - Slot full: stall in WR with wr=0, addr1=(i+1) mod N, addr2=(i+M) mod N. Do registers re-read identical unchanged words, so data stays stable.
- Output register: out_valid cleared on handshake unless reloaded the same cycle. out_data stable while out_valid && !out_ready.
- Throughput: 1 word per 2 cycles with out_ready=1.
- Latency: first out_valid high 626 cycles after the seed-accept edge.
- Wrap: i=N-1 reads x[0] (already new) on port 1; i>=N-M reads already-updated words on port 2. Both are intended MT19937 semantics.
- Simultaneous seed_valid and WR handshake: seed wins; no write, out_valid=0.

Optional Feature:
MT_TEMPER_EN
- Defined: T(x) is the MT19937 tempering (y^=y>>11; y^=(y<<7)&0x9D2C5680; y^=(y<<15)&0xEFC60000; y^=y>>18), combinational before the out_data register.
- Undefined: T(x)=x; raw state words are output for debug.
- Latency and handshake identical in both builds.

Test Plan:
- Seed with MT_TEMPER_EN: reset, seed=5489, out_ready=1 -> SRAM[0]=5489, SRAM[1]=1301868182; busy high 624 cycles; outputs 3499211612, 581869302, 3890346734; first out_valid 626 cycles after the seed edge.
- Long run: seed=5489, consume 10000 words -> word 10000 = 4123659995; i wraps 0..623 repeatedly; sram_addr2 never >= N.
- Backpressure: out_ready=0 for 10 cycles after first out_valid -> out_data held at 3499211612, sram_wr=0, no i advance; then out_ready=1 -> sequence continues unchanged.
- Reseed mid-run: seed_valid with seed=1 during WR with a pending word -> out_valid drops next cycle; 624-cycle SEED; first output 1791095845.
- Reset mid-SEED: rst_n=0 at k=300 -> all outputs at reset values immediately (async); IDLE, no writes until next seed_valid.
- Untempered build (MT_TEMPER_EN undefined): seed=5489 -> first out_data equals the raw new x[0], matching the reference model's untempered value.
